// File: rtl/onehot_encoder_serial.sv
// ============================================================================
// Module   : onehot_encoder_serial
// Purpose  : Captures an N-line decoded vector and emits each set line as a
//            binary index over a valid/ready handshake, lowest line first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module onehot_encoder_serial #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         d_in,
  input  logic                 d_load,
  output logic                 load_ready,
  output logic [$clog2(N)-1:0] idx_out,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 multi_hot,
  output logic                 none_hot,
  output logic                 done
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           multi_hot_q, multi_hot_d;
  logic           none_hot_q, none_hot_d;
  logic           done_q, done_d;

  logic           load_fire;
  logic           xfer;
  logic [N-1:0]   pending_clr;
  logic [IDX_W-1:0] lowest_idx;

  assign load_ready = en & (state_q == IDLE);
  assign idx_valid  = en & (state_q == SERVE);
  assign load_fire  = d_load & load_ready;
  assign xfer       = idx_valid & idx_ready;

  // Clearing the lowest set bit leaves the remaining lines for later transfers.
  assign pending_clr = pending_q & (pending_q - N'(1));

  always_comb begin
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lowest_idx = IDX_W'(i);
      end
    end
  end

  assign idx_out   = lowest_idx;
  assign multi_hot = multi_hot_q;
  assign none_hot  = none_hot_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    multi_hot_d = multi_hot_q;
    none_hot_d  = 1'b0;
    done_d      = 1'b0;

    if (load_fire) begin
      if (d_in != '0) begin
        pending_d   = d_in;
        multi_hot_d = |(d_in & (d_in - N'(1)));
        state_d     = SERVE;
      end else begin
        none_hot_d  = 1'b1;
      end
    end

    if (xfer) begin
      pending_d = pending_clr;
      if (pending_clr == '0) begin
        state_d     = IDLE;
        multi_hot_d = 1'b0;
        done_d      = 1'b1;
      end
    end
  end

  // Pulse flops load every cycle so an already-scheduled pulse fires even with en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      multi_hot_q <= 1'b0;
      none_hot_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      multi_hot_q <= multi_hot_d;
      none_hot_q  <= none_hot_d;
      done_q      <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_onehot_encoder_serial.sv
// ============================================================================
// Module   : tb_onehot_encoder_serial
// Purpose  : Directed self-checking bench for onehot_encoder_serial.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_onehot_encoder_serial;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] d_in;
  logic       d_load;
  logic       load_ready;
  logic [1:0] idx_out;
  logic       idx_valid;
  logic       idx_ready;
  logic       multi_hot;
  logic       none_hot;
  logic       done;

  int checks;
  int failures;

  onehot_encoder_serial #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .d_in       (d_in),
    .d_load     (d_load),
    .load_ready (load_ready),
    .idx_out    (idx_out),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .multi_hot  (multi_hot),
    .none_hot   (none_hot),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    d_in   = v;
    d_load = 1'b1;
    step();
    d_load = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    d_in      = '0;
    d_load    = 1'b0;
    idx_ready = 1'b0;
    step();
    check("rst_idx_valid",  32'(idx_valid),  32'd0);
    check("rst_idx_out",    32'(idx_out),    32'd0);
    check("rst_multi_hot",  32'(multi_hot),  32'd0);
    check("rst_none_hot",   32'(none_hot),   32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // 1: single line 0100
    load(4'b0100);
    check("t1_valid", 32'(idx_valid),  32'd1);
    check("t1_idx",   32'(idx_out),    32'd2);
    check("t1_multi", 32'(multi_hot),  32'd0);
    check("t1_lr",    32'(load_ready), 32'd0);
    idx_ready = 1'b1;
    step();
    check("t1_done",  32'(done),       32'd1);
    check("t1_idle",  32'(load_ready), 32'd1);
    check("t1_novld", 32'(idx_valid),  32'd0);
    idx_ready = 1'b0;
    step();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2: back-to-back 1011 -> 0,1,3
    idx_ready = 1'b1;
    load(4'b1011);
    check("t2_idx0",   32'(idx_out),   32'd0);
    check("t2_multi0", 32'(multi_hot), 32'd1);
    step();
    check("t2_idx1",   32'(idx_out),   32'd1);
    check("t2_nodone", 32'(done),      32'd0);
    step();
    check("t2_idx3",   32'(idx_out),   32'd3);
    check("t2_multi3", 32'(multi_hot), 32'd1);
    check("t2_valid3", 32'(idx_valid), 32'd1);
    step();
    check("t2_done",   32'(done),      32'd1);
    check("t2_mclr",   32'(multi_hot), 32'd0);
    check("t2_novld",  32'(idx_valid), 32'd0);
    idx_ready = 1'b0;
    step();

    // 3: backpressure on 1001
    load(4'b1001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_idx", 32'(idx_out),   32'd0);
      check("t3_hold_vld", 32'(idx_valid), 32'd1);
    end
    idx_ready = 1'b1;
    step();
    check("t3_idx3", 32'(idx_out), 32'd3);
    step();
    check("t3_done", 32'(done), 32'd1);
    idx_ready = 1'b0;
    step();

    // 4: all-zero load
    load(4'b0000);
    check("t4_none",  32'(none_hot),   32'd1);
    check("t4_lr",    32'(load_ready), 32'd1);
    check("t4_novld", 32'(idx_valid),  32'd0);
    step();
    check("t4_none_pulse", 32'(none_hot),  32'd0);
    check("t4_novld2",     32'(idx_valid), 32'd0);

    // 5: en freeze on 0110
    load(4'b0110);
    check("t5_idx1", 32'(idx_out), 32'd1);
    idx_ready = 1'b1;
    step();
    check("t5_idx2", 32'(idx_out), 32'd2);
    en = 1'b0;
    #1;
    check("t5_off_vld", 32'(idx_valid),  32'd0);
    check("t5_off_lr",  32'(load_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_frz_idx",  32'(idx_out),   32'd2);
      check("t5_frz_vld",  32'(idx_valid), 32'd0);
      check("t5_frz_done", 32'(done),      32'd0);
    end
    en = 1'b1;
    #1;
    check("t5_resume_vld", 32'(idx_valid), 32'd1);
    check("t5_resume_idx", 32'(idx_out),   32'd2);
    step();
    check("t5_done", 32'(done), 32'd1);
    idx_ready = 1'b0;
    step();

    // 6: reset mid-SERVE on 1111
    idx_ready = 1'b1;
    load(4'b1111);
    check("t6_idx0", 32'(idx_out), 32'd0);
    step();
    check("t6_idx1", 32'(idx_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld",   32'(idx_valid), 32'd0);
    check("t6_rst_idx",   32'(idx_out),   32'd0);
    check("t6_rst_multi", 32'(multi_hot), 32'd0);
    step();
    check("t6_rst_nodone", 32'(done), 32'd0);
    rst_n     = 1'b1;
    idx_ready = 1'b0;
    step();
    check("t6_nodone_after", 32'(done), 32'd0);
    load(4'b0001);
    check("t6_idx",   32'(idx_out),   32'd0);
    check("t6_vld",   32'(idx_valid), 32'd1);
    check("t6_multi", 32'(multi_hot), 32'd0);
    idx_ready = 1'b1;
    step();
    check("t6_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
